// File: rtl/i2s_adc_rx.sv
// I2S ADC serial-port receiver: synchronizes BCLK/LRC/DAT into clk_50m and
// captures frame-accurate stereo samples plus an offset-binary mono word.
module i2s_adc_rx #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic              enable,
    input  logic              err_clr,
    input  logic              i2s_bclk,
    input  logic              i2s_lrc,
    input  logic              i2s_dat,
    output logic [DATA_W-1:0] left_data,
    output logic [DATA_W-1:0] right_data,
    output logic [DATA_W-1:0] mono_positive,
    output logic              sample_valid,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
    logic [SYNC_STAGES-1:0] lrc_sync_q, lrc_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic                   bclk_hist_q, bclk_hist_d;
    logic                   lrc_prev_q, lrc_prev_d;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]      sr_q, sr_d;
    logic [DATA_W-1:0]      left_hold_q, left_hold_d;
    logic [DATA_W-1:0]      left_data_q, left_data_d;
    logic [DATA_W-1:0]      right_data_q, right_data_d;
    logic [DATA_W-1:0]      mono_q, mono_d;
    logic                   valid_q, valid_d;
    logic                   frame_err_q, frame_err_d;

    logic                   bclk_s, lrc_s, dat_s;
    logic                   bclk_rise, lrc_edge;
    logic                   has_room, word_full, err_set;
    logic [DATA_W-1:0]      sr_nxt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic [DATA_W:0]        sum;

    assign bclk_s = bclk_sync_q[SYNC_STAGES-1];
    assign lrc_s  = lrc_sync_q[SYNC_STAGES-1];
    assign dat_s  = dat_sync_q[SYNC_STAGES-1];

    always_comb begin
        bclk_sync_d  = {bclk_sync_q[SYNC_STAGES-2:0], i2s_bclk};
        lrc_sync_d   = {lrc_sync_q[SYNC_STAGES-2:0], i2s_lrc};
        dat_sync_d   = {dat_sync_q[SYNC_STAGES-2:0], i2s_dat};
        bclk_hist_d  = bclk_s;
        lrc_prev_d   = lrc_prev_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        sr_d         = sr_q;
        left_hold_d  = left_hold_q;
        left_data_d  = left_data_q;
        right_data_d = right_data_q;
        mono_d       = mono_q;
        valid_d      = 1'b0;
        err_set      = 1'b0;

        bclk_rise = bclk_s & ~bclk_hist_q;
        lrc_edge  = bclk_rise & (lrc_s != lrc_prev_q);

        // Bits past DATA_W (long slots) are dropped by saturating the counter.
        has_room  = (cnt_q < CNT_W'(DATA_W));
        sr_nxt    = has_room ? {sr_q[DATA_W-2:0], dat_s} : sr_q;
        cnt_nxt   = has_room ? cnt_q + 1'b1 : cnt_q;
        word_full = (cnt_nxt == CNT_W'(DATA_W));

        sum = {left_hold_q[DATA_W-1], left_hold_q} + {sr_nxt[DATA_W-1], sr_nxt};

        if (bclk_rise) begin
            lrc_prev_d = lrc_s;
        end

        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (bclk_rise) begin
            case (state_q)
                ST_IDLE: begin
                    if (lrc_edge && !lrc_s) begin
                        state_d = ST_LEFT;
                        cnt_d   = '0;
                    end
                end
                ST_LEFT: begin
                    // The edge bit is the previous word's LSB, so it is shifted first.
                    if (lrc_edge) begin
                        cnt_d = '0;
                        if (word_full) begin
                            left_hold_d = sr_nxt;
                            state_d     = ST_RIGHT;
                        end else begin
                            err_set = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        sr_d  = sr_nxt;
                        cnt_d = cnt_nxt;
                    end
                end
                ST_RIGHT: begin
                    if (lrc_edge) begin
                        cnt_d   = '0;
                        state_d = ST_LEFT;
                        if (word_full) begin
                            left_data_d  = left_hold_q;
                            right_data_d = sr_nxt;
                            mono_d       = {~sum[DATA_W], sum[DATA_W-1:1]};
                            valid_d      = 1'b1;
                        end else begin
                            err_set = 1'b1;
                        end
                    end else begin
                        sr_d  = sr_nxt;
                        cnt_d = cnt_nxt;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        frame_err_d = err_set | (frame_err_q & ~err_clr);
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            bclk_sync_q  <= '0;
            lrc_sync_q   <= '0;
            dat_sync_q   <= '0;
            bclk_hist_q  <= 1'b0;
            lrc_prev_q   <= 1'b0;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            sr_q         <= '0;
            left_hold_q  <= '0;
            left_data_q  <= '0;
            right_data_q <= '0;
            mono_q       <= {1'b1, {(DATA_W-1){1'b0}}};
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            bclk_sync_q  <= bclk_sync_d;
            lrc_sync_q   <= lrc_sync_d;
            dat_sync_q   <= dat_sync_d;
            bclk_hist_q  <= bclk_hist_d;
            lrc_prev_q   <= lrc_prev_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sr_q         <= sr_d;
            left_hold_q  <= left_hold_d;
            left_data_q  <= left_data_d;
            right_data_q <= right_data_d;
            mono_q       <= mono_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign left_data     = left_data_q;
    assign right_data    = right_data_q;
    assign mono_positive = mono_q;
    assign sample_valid  = valid_q;
    assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_i2s_adc_rx.sv
// Directed + randomized bench for i2s_adc_rx: drives I2S frames bit by bit and
// compares captured samples against an arithmetic model of the frame rules.
module tb_i2s_adc_rx;

    localparam int DW = 16;

    logic          clk_50m = 1'b0;
    logic          rst;
    logic          enable;
    logic          err_clr;
    logic          i2s_bclk;
    logic          i2s_lrc;
    logic          i2s_dat;
    logic [DW-1:0] left_data;
    logic [DW-1:0] right_data;
    logic [DW-1:0] mono_positive;
    logic          sample_valid;
    logic          frame_err;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int exp_valid_cnt = 0;

    logic [3*DW-1:0] exp_q[$];
    logic [DW-1:0]   held_l, held_r, held_m;
    logic            exp_err;
    logic            last_bit;
    logic            left_open;
    logic            prev_valid;

    i2s_adc_rx #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
        .clk_50m       (clk_50m),
        .rst           (rst),
        .enable        (enable),
        .err_clr       (err_clr),
        .i2s_bclk      (i2s_bclk),
        .i2s_lrc       (i2s_lrc),
        .i2s_dat       (i2s_dat),
        .left_data     (left_data),
        .right_data    (right_data),
        .mono_positive (mono_positive),
        .sample_valid  (sample_valid),
        .frame_err     (frame_err)
    );

    always #10 clk_50m = ~clk_50m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Top DATA_W bits of an n-bit slot word.
    function automatic logic [DW-1:0] trunc(input logic [31:0] w, input int n);
        logic [31:0] t;
        t = w >> (n - DW);
        return t[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] mono_of(input logic [DW-1:0] l, input logic [DW-1:0] r);
        int s;
        int m;
        logic [31:0] mv;
        s  = int'($signed(l)) + int'($signed(r));
        m  = s >>> 1;
        mv = m;
        return mv[DW-1:0] ^ 16'h8000;
    endfunction

    // Scoreboard: every valid pulse must match the oldest expected sample.
    always @(negedge clk_50m) begin
        if (sample_valid) begin
            logic [3*DW-1:0] e;
            valid_cnt++;
            chk("valid_width", {31'd0, prev_valid}, 32'd0);
            chk("valid_expected", exp_q.size() > 0 ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("mon_left", {16'd0, left_data}, {16'd0, e[3*DW-1:2*DW]});
                chk("mon_right", {16'd0, right_data}, {16'd0, e[2*DW-1:DW]});
                chk("mon_mono", {16'd0, mono_positive}, {16'd0, e[DW-1:0]});
            end
        end
        prev_valid = sample_valid;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bclk_cycle(input logic lrc, input logic d);
        i2s_lrc = lrc;
        i2s_dat = d;
        #160;
        i2s_bclk = 1'b1;
        #160;
        i2s_bclk = 1'b0;
    endtask

    task automatic disrupt(input int kind);
        if (kind == 1) begin
            enable = 1'b0;
            repeat (100) @(negedge clk_50m);
            enable = 1'b1;
        end else if (kind == 2) begin
            @(negedge clk_50m);
            rst = 1'b1;
            @(negedge clk_50m);
            rst = 1'b0;
            held_l  = 16'h0000;
            held_r  = 16'h0000;
            held_m  = 16'h8000;
            exp_err = 1'b0;
            chk("midrst_left", {16'd0, left_data}, 32'h0);
            chk("midrst_right", {16'd0, right_data}, 32'h0);
            chk("midrst_mono", {16'd0, mono_positive}, 32'h8000);
            chk("midrst_err", {31'd0, frame_err}, 32'd0);
        end
    endtask

    // Slot cycle 0 carries the previous word's LSB (one-bit delay).
    task automatic send_word(input logic lrc, input logic [31:0] w, input int n,
                             input int act_at, input int act_kind);
        logic b;
        for (int i = 0; i < n; i++) begin
            if (i == 0 && left_open && !lrc) begin
                left_open = 1'b0;
            end else begin
                if (i == act_at) disrupt(act_kind);
                b = (i == 0) ? last_bit : w[n-i];
                bclk_cycle(lrc, b);
            end
        end
        left_open = 1'b0;
        last_bit  = w[0];
    endtask

    task automatic close_frame();
        bclk_cycle(1'b0, last_bit);
        left_open = 1'b1;
    endtask

    task automatic checkpoint(input string tag);
        repeat (20) @(negedge clk_50m);
        chk({tag, "_pending"}, exp_q.size(), 32'd0);
        chk({tag, "_valids"}, valid_cnt, exp_valid_cnt);
        chk({tag, "_left"}, {16'd0, left_data}, {16'd0, held_l});
        chk({tag, "_right"}, {16'd0, right_data}, {16'd0, held_r});
        chk({tag, "_mono"}, {16'd0, mono_positive}, {16'd0, held_m});
        chk({tag, "_err"}, {31'd0, frame_err}, {31'd0, exp_err});
    endtask

    task automatic run_frame(input logic [31:0] l, input int nl, input logic [31:0] r, input int nr,
                             input logic expect_valid, input int act_at, input int act_kind,
                             input string tag);
        logic [DW-1:0] el, er;
        send_word(1'b0, l, nl, act_at, act_kind);
        send_word(1'b1, r, nr, -1, 0);
        if (expect_valid) begin
            el = trunc(l, nl);
            er = trunc(r, nr);
            held_l = el;
            held_r = er;
            held_m = mono_of(el, er);
            exp_q.push_back({held_l, held_r, held_m});
            exp_valid_cnt++;
        end
        close_frame();
        checkpoint(tag);
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        err_clr   = 1'b0;
        i2s_bclk  = 1'b0;
        i2s_lrc   = 1'b1;
        i2s_dat   = 1'b0;
        last_bit  = 1'b0;
        left_open = 1'b0;
        prev_valid = 1'b0;
        held_l    = 16'h0000;
        held_r    = 16'h0000;
        held_m    = 16'h8000;
        exp_err   = 1'b0;

        @(negedge clk_50m);
        for (int i = 0; i < 4; i++) bclk_cycle(1'b1, 1'($urandom_range(0, 1)));
        rst = 1'b0;
        chk("reset_left", {16'd0, left_data}, 32'h0);
        chk("reset_right", {16'd0, right_data}, 32'h0);
        chk("reset_mono", {16'd0, mono_positive}, 32'h8000);
        chk("reset_valid", {31'd0, sample_valid}, 32'd0);
        chk("reset_err", {31'd0, frame_err}, 32'd0);

        // First frame after reset only arms capture at its closing edge.
        run_frame($urandom, 16, $urandom, 16, 1'b0, -1, 0, "prime");

        run_frame(32'h1234, 16, 32'hEDCC, 16, 1'b1, -1, 0, "basic");
        run_frame(32'h7FFF, 16, 32'h7FFF, 16, 1'b1, -1, 0, "max");
        run_frame(32'h8000, 16, 32'h8000, 16, 1'b1, -1, 0, "min");
        run_frame(32'hABCD_1111, 32, 32'h0001_FFFF, 32, 1'b1, -1, 0, "slot32");

        exp_err = 1'b1;
        run_frame($urandom, 16, $urandom, 12, 1'b0, -1, 0, "short");
        run_frame($urandom, 16, $urandom, 16, 1'b1, -1, 0, "after_short");
        @(negedge clk_50m);
        err_clr = 1'b1;
        @(negedge clk_50m);
        err_clr = 1'b0;
        exp_err = 1'b0;
        @(negedge clk_50m);
        chk("err_clr", {31'd0, frame_err}, 32'd0);

        run_frame($urandom, 16, $urandom, 16, 1'b0, 8, 1, "en_drop");
        run_frame($urandom, 16, $urandom, 16, 1'b1, -1, 0, "after_en");

        run_frame($urandom, 16, $urandom, 16, 1'b0, 5, 2, "mid_rst");
        run_frame($urandom, 16, $urandom, 16, 1'b1, -1, 0, "after_rst");

        for (int k = 0; k < 8; k++) begin
            int nl, nr;
            nl = 16 + 8 * $urandom_range(0, 2);
            nr = 16 + 8 * $urandom_range(0, 2);
            run_frame($urandom, nl, $urandom, nr, 1'b1, -1, 0, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
